// File: rtl/tom_bus_arbiter.sv
// Fixed-priority main-bus arbiter for TOM: one-hot registered grant, enforced
// turnaround gap between owners, and tenure-bounded preemption by higher masters.

module tom_bus_arbiter_lane (
  input  logic req_i,
  input  logic above_i,
  output logic win_o,
  output logic above_o
);
  // above_i: some higher-priority (lower-index) master is requesting
  assign win_o   = req_i & ~above_i;
  assign above_o = above_i | req_i;
endmodule

module tom_bus_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int TURN     = 1
) (
  input  logic                 sys_clk,
  input  logic                 xresetl,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 aen,
  output logic                 preempt
);
  localparam int OW = $clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [3:0]    TURN_LAST = 4'(TURN - 1);

  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            aen_q, aen_d;
  logic            preempt_q, preempt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [3:0]      turn_q, turn_d;

  logic [N:0]      above;
  logic [N-1:0]    win;
  logic [OW-1:0]   win_idx;
  logic            hp_wait;

  // Priority chain: above[i] = any req[j] with j < i; above[N] = any request.
  assign above[0] = 1'b0;
  tom_bus_arbiter_lane u_lane [N-1:0] (
    .req_i   (req),
    .above_i (above[N-1:0]),
    .win_o   (win),
    .above_o (above[N:1])
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++)
      if (win[i]) win_idx = win_idx | OW'(i);
  end

  assign hp_wait = above[owner_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (above[N]) begin
          state_d = OWN;
          gnt_d   = win;
          owner_d = win_idx;
          hold_d  = '0;
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          state_d = RELEASE;
          gnt_d   = '0;
          turn_d  = '0;
        // Saturated counter keeps the condition true, so a late higher request still preempts.
        end else if (PREEMPT_EN && (hold_q >= HOLD_LAST) && hp_wait) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          turn_d    = '0;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      RELEASE: begin
        if (turn_q == TURN_LAST) state_d = IDLE;
        else                     turn_d  = turn_q + 4'd1;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
    aen_d  = |gnt_d;
  end

  always_ff @(posedge sys_clk or negedge xresetl) begin
    if (!xresetl) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      aen_q     <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
      turn_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      aen_q     <= aen_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign aen     = aen_q;
  assign preempt = preempt_q;
endmodule

// File: tb/tb_tom_bus_arbiter.sv
// Scoreboarded bench for tom_bus_arbiter: three configurations driven by one
// request stream, directed scenarios on the default instance, then a random soak.

module tb_tom_bus_arbiter;
  localparam int NC = 3;
  localparam int MH [NC] = '{16, 4, 0};
  localparam int TN [NC] = '{1, 3, 3};

  logic       sys_clk = 1'b0;
  logic       xresetl;
  logic [7:0] req;
  logic [7:0] gnt_o  [NC];
  logic [2:0] own_o  [NC];
  logic       busy_o [NC];
  logic       aen_o  [NC];
  logic       pre_o  [NC];

  always #5 sys_clk = ~sys_clk;

  tom_bus_arbiter #(.N(8), .MAX_HOLD(16), .TURN(1)) u_dut0 (
    .sys_clk(sys_clk), .xresetl(xresetl), .req(req), .gnt(gnt_o[0]), .owner(own_o[0]),
    .busy(busy_o[0]), .aen(aen_o[0]), .preempt(pre_o[0]));
  tom_bus_arbiter #(.N(8), .MAX_HOLD(4), .TURN(3)) u_dut1 (
    .sys_clk(sys_clk), .xresetl(xresetl), .req(req), .gnt(gnt_o[1]), .owner(own_o[1]),
    .busy(busy_o[1]), .aen(aen_o[1]), .preempt(pre_o[1]));
  tom_bus_arbiter #(.N(8), .MAX_HOLD(0), .TURN(3)) u_dut2 (
    .sys_clk(sys_clk), .xresetl(xresetl), .req(req), .gnt(gnt_o[2]), .owner(own_o[2]),
    .busy(busy_o[2]), .aen(aen_o[2]), .preempt(pre_o[2]));

  typedef struct packed {
    logic [NC-1:0][7:0] gnt;
    logic [NC-1:0][2:0] own;
    logic [NC-1:0]      busy;
    logic [NC-1:0]      pre;
  } exp_t;

  exp_t sbq [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state: 0 idle, 1 owned, 2 turnaround
  int mst [NC], mw [NC], mhold [NC], mturn [NC], mpre [NC];
  int w0 [NC], w0max [NC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mst[c] = 0; mw[c] = 0; mhold[c] = 0; mturn[c] = 0; mpre[c] = 0; w0[c] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] r);
    int top;
    for (int c = 0; c < NC; c++) begin
      mpre[c] = 0;
      if (mst[c] == 0) begin
        if (r != 0) begin
          top = 7;
          for (int i = 7; i >= 0; i--) if (r[i]) top = i;
          mw[c] = top; mhold[c] = 0; mst[c] = 1;
        end
      end else if (mst[c] == 1) begin
        if (!r[mw[c]]) begin
          mst[c] = 2; mturn[c] = 0;
        end else if (MH[c] != 0 && mhold[c] >= MH[c] - 1 && (r & ((8'd1 << mw[c]) - 8'd1)) != 0) begin
          mst[c] = 2; mturn[c] = 0; mpre[c] = 1;
        end else if (mhold[c] < MH[c]) begin
          mhold[c]++;
        end
      end else begin
        if (mturn[c] == TN[c] - 1) mst[c] = 0;
        else mturn[c]++;
      end
    end
  endtask

  task automatic score();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("gnt%0d", c), gnt_o[c], e.gnt[c]);
      chk($sformatf("busy%0d", c), busy_o[c], e.busy[c]);
      chk($sformatf("aen%0d", c), aen_o[c], e.gnt[c] != 0);
      chk($sformatf("pre%0d", c), pre_o[c], e.pre[c]);
      if (e.busy[c]) chk($sformatf("own%0d", c), own_o[c], e.own[c]);
      if (req[0] && !gnt_o[c][0]) w0[c]++;
      else w0[c] = 0;
      if (w0[c] > w0max[c]) w0max[c] = w0[c];
    end
  endtask

  task automatic cyc(input logic [7:0] r);
    exp_t e;
    req = r;
    model_step(r);
    for (int c = 0; c < NC; c++) begin
      e.gnt[c]  = (mst[c] == 1) ? 8'(1 << mw[c]) : 8'h00;
      e.own[c]  = 3'(mw[c]);
      e.busy[c] = (mst[c] != 0);
      e.pre[c]  = (mpre[c] != 0);
    end
    sbq.push_back(e);
    @(posedge sys_clk);
    @(negedge sys_clk);
    score();
  endtask

  initial begin
    logic [7:0] r;
    for (int c = 0; c < NC; c++) w0max[c] = 0;
    xresetl = 1'b0;
    req     = 8'h00;
    model_reset();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_gnt", gnt_o[0], 8'h00);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_aen", aen_o[0], 0);
    chk("rst_pre", pre_o[0], 0);
    chk("rst_own", own_o[0], 3'd0);
    xresetl = 1'b1;

    // single master
    cyc(8'h80);
    chk("t2_gnt", gnt_o[0], 8'h80);
    chk("t2_own", own_o[0], 3'd7);
    repeat (3) cyc(8'h80);
    cyc(8'h00);
    chk("t2_drop_gnt", gnt_o[0], 8'h00);
    chk("t2_drop_busy", busy_o[0], 1);
    cyc(8'h00);
    chk("t2_idle_busy", busy_o[0], 0);

    // asynchronous reset mid-tenure, then immediate re-grant
    cyc(8'h80);
    cyc(8'h80);
    xresetl = 1'b0;
    #1;
    chk("t1_gnt", gnt_o[0], 8'h00);
    chk("t1_busy", busy_o[0], 0);
    chk("t1_aen", aen_o[0], 0);
    model_reset();
    #2 xresetl = 1'b1;
    cyc(8'h80);
    chk("t1_regrant", gnt_o[0], 8'h80);
    cyc(8'h00);
    cyc(8'h00);

    // priority and turnaround
    cyc(8'h24);
    chk("t3_gnt", gnt_o[0], 8'h04);
    cyc(8'h24);
    cyc(8'h20);
    chk("t3_rel", gnt_o[0], 8'h00);
    cyc(8'h20);
    chk("t3_gap", gnt_o[0], 8'h00);
    cyc(8'h20);
    chk("t3_next", gnt_o[0], 8'h20);
    cyc(8'h00);
    cyc(8'h00);

    // preemption of CPU by refresh
    cyc(8'h80);
    cyc(8'h80);
    cyc(8'h80);
    for (int i = 0; i < 13; i++) begin
      cyc(8'h81);
      chk("t4_hold", gnt_o[0], 8'h80);
    end
    cyc(8'h81);
    chk("t4_pre_gnt", gnt_o[0], 8'h00);
    chk("t4_pre", pre_o[0], 1);
    cyc(8'h81);
    chk("t4_pre_off", pre_o[0], 0);
    cyc(8'h81);
    chk("t4_ref", gnt_o[0], 8'h01);
    cyc(8'h81);
    cyc(8'h80);
    cyc(8'h80);
    cyc(8'h80);
    chk("t4_cpu_back", gnt_o[0], 8'h80);
    cyc(8'h00);
    cyc(8'h00);
    cyc(8'h00);
    cyc(8'h00);

    // lower priority never preempts
    cyc(8'h44);
    for (int i = 0; i < 40; i++) begin
      cyc(8'h44);
      chk("t5_gnt", gnt_o[0], 8'h04);
      chk("t5_pre", pre_o[0], 0);
    end
    cyc(8'h00);
    cyc(8'h00);
    cyc(8'h00);
    cyc(8'h00);

    // random soak with slowly toggling requests
    r = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      cyc(r);
    end
    chk("starve0", w0max[0] <= MH[0] + TN[0] + 2, 1);
    chk("starve1", w0max[1] <= MH[1] + TN[1] + 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
